auth_lockout_ctrl: RTL

AUTH_LOCKOUT_CTRL -- requirements
Module: auth_lockout_ctrl

---
 rtl/auth_lockout_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/auth_lockout_ctrl.sv
// auth_lockout_ctrl: attempt-counting access controller with an unlocked window
// and a timed lockout after MAX_FAILS consecutive bad attempts.
// Optional feature macro: CITADEL_LOCKOUT_ESCALATE_EN. When it is defined, each
// lockout doubles the next lockout duration, up to three doublings. A successful
// unlock or a reset clears the doubling level.
module auth_lockout_ctrl #(
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 1024,
  parameter int unsigned UNLOCK_CYCLES  = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       attempt_valid,
  input  logic       is_authorized,
  input  logic       relock,
  output logic       attempt_ready,
  output logic       unlocked,
  output logic       locked_out,
  output logic       alarm,
  output logic [3:0] fail_count
);

  localparam int unsigned TIMER_W = 20;
  localparam int unsigned FC_W    = 4;

  typedef enum logic [1:0] {
    ST_ARMED    = 2'd0,
    ST_UNLOCKED = 2'd1,
    ST_LOCKOUT  = 2'd2
  } state_t;

  state_t              r_state;
  logic [TIMER_W-1:0]  r_timer;
  logic [FC_W-1:0]     r_fail_count;
  logic                r_ready;
  logic                r_unlocked;
  logic                r_locked_out;
  logic                r_alarm;

  logic [FC_W:0]       w_fail_next;
  logic                w_accept;
  logic                w_trip;
  logic                w_expire;
  logic [TIMER_W-1:0]  w_timer_dec;
  logic [TIMER_W-1:0]  w_lock_dur;

  // Attempt acceptance, failure threshold and timer helpers.
  assign w_accept    = attempt_valid && (r_state == ST_ARMED);
  assign w_fail_next = {1'b0, r_fail_count} + (FC_W+1)'(1);
  assign w_trip      = (w_fail_next >= (FC_W+1)'(MAX_FAILS));
  assign w_expire    = (r_timer <= TIMER_W'(1));
  assign w_timer_dec = (r_timer != '0) ? (r_timer - TIMER_W'(1)) : '0;

`ifdef CITADEL_LOCKOUT_ESCALATE_EN
  logic [1:0] r_level;

  // Lockout duration grows with the escalation level.
  assign w_lock_dur = TIMER_W'(LOCKOUT_CYCLES) << r_level;

  // Escalation level: saturating bump on each lockout entry, cleared by a good unlock.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_level <= 2'd0;
    end else if (w_accept && is_authorized) begin
      r_level <= 2'd0;
    end else if (w_accept && w_trip && (r_level != 2'd3)) begin
      r_level <= r_level + 2'd1;
    end
  end
`else
  // Fixed lockout duration.
  assign w_lock_dur = TIMER_W'(LOCKOUT_CYCLES);
`endif

  // Main FSM with registered outputs and the shared window/lockout timer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_ARMED;
      r_timer      <= '0;
      r_fail_count <= '0;
      r_ready      <= 1'b1;
      r_unlocked   <= 1'b0;
      r_locked_out <= 1'b0;
      r_alarm      <= 1'b0;
    end else begin
      r_alarm <= 1'b0;
      case (r_state)
        ST_ARMED: begin
          if (w_accept) begin
            if (is_authorized) begin
              r_state      <= ST_UNLOCKED;
              r_unlocked   <= 1'b1;
              r_ready      <= 1'b0;
              r_fail_count <= '0;
              r_timer      <= TIMER_W'(UNLOCK_CYCLES);
            end else if (w_trip) begin
              r_state      <= ST_LOCKOUT;
              r_locked_out <= 1'b1;
              r_alarm      <= 1'b1;
              r_ready      <= 1'b0;
              r_fail_count <= FC_W'(MAX_FAILS);
              r_timer      <= w_lock_dur;
            end else begin
              r_fail_count <= w_fail_next[FC_W-1:0];
            end
          end
        end
        ST_UNLOCKED: begin
          // Early relock and natural expiry lead to the same single return.
          if (relock || w_expire) begin
            r_state    <= ST_ARMED;
            r_unlocked <= 1'b0;
            r_ready    <= 1'b1;
            r_timer    <= '0;
          end else begin
            r_timer <= w_timer_dec;
          end
        end
        ST_LOCKOUT: begin
          if (w_expire) begin
            r_state      <= ST_ARMED;
            r_locked_out <= 1'b0;
            r_ready      <= 1'b1;
            r_fail_count <= '0;
            r_timer      <= '0;
          end else begin
            r_timer <= w_timer_dec;
          end
        end
        default: begin
          r_state      <= ST_ARMED;
          r_unlocked   <= 1'b0;
          r_locked_out <= 1'b0;
          r_ready      <= 1'b1;
          r_fail_count <= '0;
          r_timer      <= '0;
        end
      endcase
    end
  end

  assign attempt_ready = r_ready;
  assign unlocked      = r_unlocked;
  assign locked_out    = r_locked_out;
  assign alarm         = r_alarm;
  assign fail_count    = r_fail_count;

endmodule
